// File: rtl/reg_bus_sequencer_pkg.sv
// Shared opcode and state definitions for the register bus sequencer.
package reg_bus_sequencer_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_NOP  = 2'b00;
  localparam opcode_t OP_MOV  = 2'b01;
  localparam opcode_t OP_SWAP = 2'b10;
  localparam opcode_t OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP1 = 2'd1,
    S_STEP2 = 2'd2,
    S_STEP3 = 2'd3
  } state_t;

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Command handshake plus bus enable signals between a command issuer and the sequencer.
interface reg_bus_sequencer_if #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2
);
  import reg_bus_sequencer_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  opcode_t             cmd_op;
  logic [IDX_W-1:0]    cmd_src;
  logic [IDX_W-1:0]    cmd_dst;
  logic [NUM_REGS-1:0] rd_en;
  logic [NUM_REGS-1:0] wr_en;
  logic                ext_oe;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst,
    input  cmd_ready, rd_en, wr_en, ext_oe, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst,
    output cmd_ready, rd_en, wr_en, ext_oe, busy, done, err
  );

endinterface

// File: rtl/reg_bus_sequencer_idx_to_onehot.sv
// Index-to-one-hot decoder; all zeros when disabled or when the index has no register.
module idx_to_onehot #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot_c
);

  // Decode the index against every register slot.
  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (en && (32'(idx) == i)) begin
        onehot_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Sequences MOV / LOAD / SWAP transfers over the shared register bus, one bus driver per cycle.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned TMP_IDX  = 3
) (
  input  logic               clk,
  input  logic               reset,
  reg_bus_sequencer_if.slave bus
);

  localparam logic [IDX_W-1:0] TMP = IDX_W'(TMP_IDX);

  state_t              state;
  state_t              state_nxt;
  opcode_t             op_q;
  logic [IDX_W-1:0]    src_q;
  logic [IDX_W-1:0]    dst_q;
  logic                rej_q;

  logic                accept_c;
  logic                rej_in_c;
  opcode_t             op_c;
  logic [IDX_W-1:0]    src_c;
  logic [IDX_W-1:0]    dst_c;
  logic                rej_c;

  logic                rd_act;
  logic [IDX_W-1:0]    rd_idx;
  logic                wr_act;
  logic [IDX_W-1:0]    wr_idx;
  logic                ext_nxt;
  logic                done_nxt;
  logic                err_nxt;
  logic [NUM_REGS-1:0] rd_onehot_c;
  logic [NUM_REGS-1:0] wr_onehot_c;

  logic [NUM_REGS-1:0] rd_en_q;
  logic [NUM_REGS-1:0] wr_en_q;
  logic                ext_oe_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  assign bus.cmd_ready = (state == S_IDLE) && !reset;
  assign accept_c      = bus.cmd_valid && bus.cmd_ready;

  // Validate the incoming command against the register range and the scratch slot.
  always_comb begin
    rej_in_c = 1'b0;
    case (bus.cmd_op)
      OP_MOV:  rej_in_c = !in_range(bus.cmd_src) || !in_range(bus.cmd_dst);
      OP_LOAD: rej_in_c = !in_range(bus.cmd_dst);
      OP_SWAP: rej_in_c = !in_range(bus.cmd_src) || !in_range(bus.cmd_dst) ||
                          (bus.cmd_src == TMP) || (bus.cmd_dst == TMP);
      default: rej_in_c = 1'b0;
    endcase
  end

  // Step 1 is entered from the accepting edge, so it uses the live command fields.
  assign op_c  = (state == S_IDLE) ? bus.cmd_op  : op_q;
  assign src_c = (state == S_IDLE) ? bus.cmd_src : src_q;
  assign dst_c = (state == S_IDLE) ? bus.cmd_dst : dst_q;
  assign rej_c = (state == S_IDLE) ? rej_in_c    : rej_q;

  // Next state and the enables for the step being entered.
  always_comb begin
    state_nxt = S_IDLE;
    rd_act    = 1'b0;
    rd_idx    = '0;
    wr_act    = 1'b0;
    wr_idx    = '0;
    ext_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      S_IDLE:  state_nxt = accept_c ? S_STEP1 : S_IDLE;
      S_STEP1: state_nxt = (op_c == OP_SWAP && !rej_c) ? S_STEP2 : S_IDLE;
      S_STEP2: state_nxt = S_STEP3;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_STEP1: begin
        if (rej_c) begin
          done_nxt = 1'b1;
          err_nxt  = 1'b1;
        end else begin
          case (op_c)
            OP_MOV: begin
              rd_act   = 1'b1;
              rd_idx   = src_c;
              wr_act   = 1'b1;
              wr_idx   = dst_c;
              done_nxt = 1'b1;
            end
            OP_LOAD: begin
              ext_nxt  = 1'b1;
              wr_act   = 1'b1;
              wr_idx   = dst_c;
              done_nxt = 1'b1;
            end
            OP_SWAP: begin
              rd_act = 1'b1;
              rd_idx = src_c;
              wr_act = 1'b1;
              wr_idx = TMP;
            end
            default: done_nxt = 1'b1;
          endcase
        end
      end
      S_STEP2: begin
        rd_act = 1'b1;
        rd_idx = dst_c;
        wr_act = 1'b1;
        wr_idx = src_c;
      end
      S_STEP3: begin
        rd_act   = 1'b1;
        rd_idx   = TMP;
        wr_act   = 1'b1;
        wr_idx   = dst_c;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  idx_to_onehot #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rd_dec (
    .idx      (rd_idx),
    .en       (rd_act),
    .onehot_c (rd_onehot_c)
  );

  idx_to_onehot #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_wr_dec (
    .idx      (wr_idx),
    .en       (wr_act),
    .onehot_c (wr_onehot_c)
  );

  // State, latched command and registered step outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      src_q    <= '0;
      dst_q    <= '0;
      rej_q    <= 1'b0;
      rd_en_q  <= '0;
      wr_en_q  <= '0;
      ext_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_c) begin
        op_q  <= bus.cmd_op;
        src_q <= bus.cmd_src;
        dst_q <= bus.cmd_dst;
        rej_q <= rej_in_c;
      end
      rd_en_q  <= rd_onehot_c;
      wr_en_q  <= wr_onehot_c;
      ext_oe_q <= ext_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      done_q   <= done_nxt;
      err_q    <= err_nxt;
    end
  end

  assign bus.rd_en  = rd_en_q;
  assign bus.wr_en  = wr_en_q;
  assign bus.ext_oe = ext_oe_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: per-cycle expectation queue plus a register-file model on the bus.
module tb_reg_bus_sequencer;
  import reg_bus_sequencer_pkg::*;

  localparam int unsigned NR  = 4;
  localparam int unsigned IW  = 2;
  localparam int unsigned TMP = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  reg_bus_sequencer_if #(.NUM_REGS(NR), .IDX_W(IW)) bus ();

  reg_bus_sequencer #(.NUM_REGS(NR), .IDX_W(IW), .TMP_IDX(TMP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] rd;
    logic [NR-1:0] wr;
    logic          ext;
    logic          busy;
    logic          done;
    logic          err;
    logic          ready;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  logic        cur_ready = 1'b0;
  logic [15:0] regs [NR] = '{16'h1111, 16'h5555, 16'h2222, 16'h0000};
  logic [15:0] ext_val   = 16'hABCD;
  logic [15:0] bus_val;
  int          n_checks  = 0;
  int          n_pass    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  function automatic exp_t mk(input logic [NR-1:0] rd, input logic [NR-1:0] wr,
                              input logic ext, input logic done, input logic err);
    exp_t e;
    e.rd = rd; e.wr = wr; e.ext = ext; e.busy = 1'b1;
    e.done = done; e.err = err; e.ready = 1'b0;
    return e;
  endfunction

  // Expected bus steps of one command, straight from the opcode rules.
  function automatic void model_push(input opcode_t op, input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic          rej;
    logic          uses_a;
    logic          uses_b;
    logic [NR-1:0] ma;
    logic [NR-1:0] mb;
    logic [NR-1:0] mt;
    ma     = NR'(1) << a;
    mb     = NR'(1) << b;
    mt     = NR'(1) << TMP;
    uses_a = (op == OP_MOV) || (op == OP_SWAP);
    uses_b = (op != OP_NOP);
    rej    = (uses_a && int'(a) >= int'(NR)) || (uses_b && int'(b) >= int'(NR)) ||
             (op == OP_SWAP && (int'(a) == int'(TMP) || int'(b) == int'(TMP)));
    if (rej || op == OP_NOP) q.push_back(mk('0, '0, 1'b0, 1'b1, rej));
    else if (op == OP_MOV)   q.push_back(mk(ma, mb, 1'b0, 1'b1, 1'b0));
    else if (op == OP_LOAD)  q.push_back(mk('0, mb, 1'b1, 1'b1, 1'b0));
    else begin
      q.push_back(mk(ma, mt, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(mb, ma, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(mt, mb, 1'b0, 1'b1, 1'b0));
    end
  endfunction

  // Register file hanging off the bus: the single driver's value lands in the written register.
  always @(posedge clk) begin
    if (!reset) begin
      bus_val = 16'h0000;
      for (int i = 0; i < int'(NR); i++) if (bus.rd_en[i]) bus_val = regs[i];
      if (bus.ext_oe) bus_val = ext_val;
      for (int i = 0; i < int'(NR); i++) if (bus.wr_en[i]) regs[i] <= bus_val;
    end
  end

  // Per-cycle comparison against the expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      ce.rd = '0; ce.wr = '0; ce.ext = 1'b0; ce.busy = 1'b0;
      ce.done = 1'b0; ce.err = 1'b0; ce.ready = 1'b0;
    end else if (q.size() > 0) begin
      ce = q.pop_front();
    end else begin
      ce.rd = '0; ce.wr = '0; ce.ext = 1'b0; ce.busy = 1'b0;
      ce.done = 1'b0; ce.err = 1'b0; ce.ready = 1'b1;
    end
    cur_ready = ce.ready;
    check("rd_en",     32'(bus.rd_en),     32'(ce.rd));
    check("wr_en",     32'(bus.wr_en),     32'(ce.wr));
    check("ext_oe",    32'(bus.ext_oe),    32'(ce.ext));
    check("busy",      32'(bus.busy),      32'(ce.busy));
    check("done",      32'(bus.done),      32'(ce.done));
    check("err",       32'(bus.err),       32'(ce.err));
    check("cmd_ready", 32'(bus.cmd_ready), 32'(ce.ready));
    check("one_driver", 32'(($countones(bus.rd_en) + int'(bus.ext_oe)) <= 1), 32'(1));
    check("one_writer", 32'($countones(bus.wr_en) <= 1), 32'(1));
  end

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk); #1;
    while (!cur_ready && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    if (!cur_ready) begin
      n_checks++;
      $display("FAIL ready_timeout: cmd_ready still low after %0d cycles", w);
    end
  endtask

  // Returns 1 ns after the accepting edge, i.e. inside the first step cycle.
  task automatic send(input opcode_t op, input logic [IW-1:0] src, input logic [IW-1:0] dst);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    model_push(op, src, dst);
  endtask

  task automatic lit(input string name, input logic [NR-1:0] rd, input logic [NR-1:0] wr,
                     input logic ext, input logic done, input logic err);
    check({name, "_rd"},   32'(bus.rd_en),  32'(rd));
    check({name, "_wr"},   32'(bus.wr_en),  32'(wr));
    check({name, "_ext"},  32'(bus.ext_oe), 32'(ext));
    check({name, "_done"}, 32'(bus.done),   32'(done));
    check({name, "_err"},  32'(bus.err),    32'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;

    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(bus.cmd_ready), 32'(0));
    #1 reset = 1'b0;
    #1 check("ready_after_reset", 32'(bus.cmd_ready), 32'(1));

    // SWAP R0,R2 through the scratch register; a stray command during the swap is ignored
    send(OP_SWAP, 2'd0, 2'd2);
    lit("swap_s1", 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_MOV; bus.cmd_src = 2'd1; bus.cmd_dst = 2'd0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lit("swap_s2", 4'b0100, 4'b0001, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    lit("swap_s3", 4'b1000, 4'b0100, 1'b0, 1'b1, 1'b0);
    wait_ready();
    check("swap_r0", 32'(regs[0]), 32'h2222);
    check("swap_r2", 32'(regs[2]), 32'h1111);

    // MOV R1 -> R2
    send(OP_MOV, 2'd1, 2'd2);
    lit("mov", 4'b0010, 4'b0100, 1'b0, 1'b1, 1'b0);
    check("mov_busy",  32'(bus.busy),      32'(1));
    check("mov_ready", 32'(bus.cmd_ready), 32'(0));
    @(posedge clk); #1;
    lit("mov_after", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("mov_after_ready", 32'(bus.cmd_ready), 32'(1));
    wait_ready();
    check("mov_r2", 32'(regs[2]), 32'h5555);

    // LOAD R3 from the external source
    send(OP_LOAD, 2'd0, 2'd3);
    lit("load", 4'b0000, 4'b1000, 1'b1, 1'b1, 1'b0);
    wait_ready();
    check("load_r3", 32'(regs[3]), 32'hABCD);

    // SWAP using the scratch index is rejected
    send(OP_SWAP, 2'd3, 2'd1);
    lit("swap_rej", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    wait_ready();
    check("rej_r1", 32'(regs[1]), 32'h5555);
    check("rej_r3", 32'(regs[3]), 32'hABCD);

    // Back-to-back short commands, including a self-move
    send(OP_NOP, 2'd2, 2'd1);
    lit("nop", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    send(OP_MOV, 2'd2, 2'd2);
    lit("mov_self", 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
    wait_ready();
    check("self_r2", 32'(regs[2]), 32'h5555);

    // Reset in the middle of SWAP R0,R1: only the scratch write has happened
    send(OP_SWAP, 2'd0, 2'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    q.delete();
    lit("abort", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("abort_busy", 32'(bus.busy), 32'(0));
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1 check("abort_ready", 32'(bus.cmd_ready), 32'(1));
    check("abort_r0", 32'(regs[0]), 32'h2222);
    check("abort_r1", 32'(regs[1]), 32'h5555);
    check("abort_r3", 32'(regs[3]), 32'h2222);

    // Recovery: MOV R0 -> R1
    send(OP_MOV, 2'd0, 2'd1);
    wait_ready();
    check("recover_r1", 32'(regs[1]), 32'h2222);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bus_sequencer.md
Name: reg_bus_sequencer

Overview:
Sequences register-to-register transfers over the shared 16-bit tri-state register bus.
- Accepts one command at a time over a valid/ready handshake.
- Issues the per-register read (bus drive) and write (bus capture) enables for each bus step.
- Guarantees at most one bus driver per cycle.
- Supports MOV (1 step), LOAD from an external bus source (1 step), and SWAP (3 steps through a scratch register).

Parameters:
NUM_REGS, 4, number of registers on the bus.
IDX_W, 2, width of register index fields; 2**IDX_W >= NUM_REGS.
TMP_IDX, 3, index of the scratch register used by SWAP.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_op  input  2  opcode: 00 NOP, 01 MOV, 10 SWAP, 11 LOAD.
cmd_src  input  IDX_W  source register index (MOV); first operand (SWAP).
cmd_dst  input  IDX_W  destination index (MOV, LOAD); second operand (SWAP).
rd_en  output  NUM_REGS  one-hot read enables (register drives the bus).
wr_en  output  NUM_REGS  one-hot write enables (register captures the bus).
ext_oe  output  1  external source drives the bus (LOAD).
busy  output  1  command in progress.
done  output  1  one-cycle pulse, concurrent with the final step of a command.
err  output  1  one-cycle pulse with done for a rejected command.

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - rd_en=0, wr_en=0, ext_oe=0, busy=0, done=0, err=0.
  - Latched command cleared.
  - cmd_ready=0 while reset is high.
- Reset mid-command: the command is abandoned. No further enables. Registers already written keep their values.
- States: IDLE, STEP1, STEP2, STEP3.
- cmd_ready = (state==IDLE) && !reset. Acceptance = cmd_valid && cmd_ready at a rising edge. op/src/dst are latched at acceptance.
- All outputs except cmd_ready are registered. Step outputs appear in the cycle after the edge that enters the step state.
- Each step lasts exactly 1 cycle. The destination register captures at the rising edge that ends the step.
- MOV: IDLE -> STEP1 -> IDLE.
  - STEP1: rd_en=onehot(src), wr_en=onehot(dst), done=1.
  - src==dst is legal and issued as-is.
- LOAD: IDLE -> STEP1 -> IDLE.
  - STEP1: ext_oe=1, rd_en=0, wr_en=onehot(dst), done=1.
- SWAP (src=a, dst=b): IDLE -> STEP1 -> STEP2 -> STEP3 -> IDLE.
  - STEP1: rd a, wr TMP.
  - STEP2: rd b, wr a.
  - STEP3: rd TMP, wr b, done=1.
  - a==b is legal.
- NOP: IDLE -> STEP1 -> IDLE. No enables; done=1.
- Error check at acceptance. A command is rejected if either:
  - any used index >= NUM_REGS, or
  - a SWAP operand equals TMP_IDX.
- Rejected command: IDLE -> STEP1 -> IDLE. No enables; done=1, err=1.
- busy=1 in every non-IDLE state.
- Throughput: a new command is accepted no earlier than the cycle after done. Spacing is 2 cycles for 1-step commands and 4 for SWAP.
- Invariants, every cycle:
  - popcount(rd_en) + ext_oe <= 1.
  - popcount(wr_en) <= 1.
  - Enables are zero in IDLE.
- cmd_* inputs are ignored while cmd_ready=0.

Decomposition:
- Shared package:
  - opcode constants OP_NOP/OP_MOV/OP_SWAP/OP_LOAD.
  - state encoding constants S_IDLE/S_STEP1/S_STEP2/S_STEP3.
  - a 2-bit opcode typedef.
- One sub-module: idx_to_onehot (parameter NUM_REGS). Converts an IDX_W index plus an enable into a NUM_REGS one-hot vector; all zeros when disabled or out of range. Instantiated twice, for rd_en and wr_en.

Test Plan:
- Reset: assert reset for 3 cycles, then release. During reset all outputs are 0 and cmd_ready=0. After release cmd_ready=1.
- MOV src=1 dst=2, accepted at edge E0:
  - Cycle after E0: rd_en=0010, wr_en=0100, done=1, busy=1, cmd_ready=0.
  - Next cycle: all enables 0, cmd_ready=1.
- SWAP a=0 b=2 with R0=16'h1111, R2=16'h2222 (bench register models):
  - Steps: rd/wr = 0001/1000, then 0100/0001, then 1000/0100.
  - done only on the third step.
  - Final R0=16'h2222, R2=16'h1111.
- LOAD dst=3 with external bus value 16'hABCD: ext_oe=1, wr_en=1000, rd_en=0000 for one cycle. R3 becomes 16'hABCD.
- SWAP a=3 (TMP) b=1: one cycle with done=1, err=1, rd_en=wr_en=0, ext_oe=0. Register contents unchanged.
- Reset during STEP2 of a SWAP: all enables drop to 0 immediately; state returns to IDLE. No done pulse. cmd_ready=1 the first cycle after reset releases.
